// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: sole owner of the 8x8 board state RAM ports.
// Shares the single write port between the board-clear sequencer and the
// move-commit writer, and the single read port between the judger and the
// LED scanner. Read returns are tagged per requester, and a write to the
// address being read in the same cycle is forwarded into the return data.
//
// Handshake: a requester holds *_req (and its address/data) as a level until
// it sees *_gnt high; the transfer happens at the clock edge ending that cycle.
// A granted read returns exactly one cycle later with *_rvalid high for one cycle.
module board_ram_arbiter #(
    parameter int DATA_BITS = 2,
    parameter int ADDR_BITS = 6,
    parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 clear_done,
    input  logic                 cm_req,
    input  logic [ADDR_BITS-1:0] cm_addr,
    input  logic [DATA_BITS-1:0] cm_data,
    output logic                 cm_gnt,
    input  logic                 jd_req,
    input  logic [ADDR_BITS-1:0] jd_addr,
    output logic                 jd_gnt,
    output logic [DATA_BITS-1:0] jd_rdata,
    output logic                 jd_rvalid,
    input  logic                 sc_req,
    input  logic [ADDR_BITS-1:0] sc_addr,
    output logic                 sc_gnt,
    output logic [DATA_BITS-1:0] sc_rdata,
    output logic                 sc_rvalid,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [DATA_BITS-1:0] ram_wr_data,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    input  logic [DATA_BITS-1:0] ram_rd_data,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS:0]   cnt_q, cnt_d;
    logic [ADDR_BITS:0]   cnt_inc;
    logic                 pri_jd_q, pri_jd_d;
    logic                 rv_jd_q, rv_sc_q;
    logic                 hz_q, hz_d;
    logic [DATA_BITS-1:0] fwd_q;
    logic [DATA_BITS-1:0] jd_hold_q, jd_hold_d;
    logic [DATA_BITS-1:0] sc_hold_q, sc_hold_d;
    logic [DATA_BITS-1:0] ret_data;
    logic                 clearing;

    assign clearing   = (state_q == S_CLEAR);
    assign clear_busy = clearing;
    assign clear_done = (state_q == S_DONE);
    assign dbg_state  = state_q;
    assign cnt_inc    = cnt_q + CNT_ONE;

    // Clear sequencer: walk every cell once, then one S_DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                // The extra counter bit sets once the last cell has been written.
                if (cnt_inc[ADDR_BITS]) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write port: the sequencer owns it while clearing, otherwise the committer.
    always_comb begin
        cm_gnt      = cm_req & ~clearing;
        ram_we      = clearing | cm_gnt;
        ram_wr_addr = clearing ? cnt_q[ADDR_BITS-1:0] : cm_addr;
        ram_wr_data = clearing ? CLEAR_VALUE : cm_data;
    end

    // Read port: round-robin between judger and scanner on contention.
    always_comb begin
        jd_gnt      = jd_req & (~sc_req | pri_jd_q);
        sc_gnt      = sc_req & ~jd_gnt;
        ram_rd_addr = jd_gnt ? jd_addr : sc_addr;
        // The requester just served loses priority; unchanged when nobody read.
        pri_jd_d    = (jd_gnt | sc_gnt) ? sc_gnt : pri_jd_q;
        // RAM is read-first, so a same-cycle write to the read address must be forwarded.
        hz_d        = (jd_gnt | sc_gnt) & ram_we & (ram_wr_addr == ram_rd_addr);
    end

    // Return data: forwarded write or RAM output; the idle port keeps its last value.
    always_comb begin
        ret_data  = hz_q ? fwd_q : ram_rd_data;
        jd_hold_d = rv_jd_q ? ret_data : jd_hold_q;
        sc_hold_d = rv_sc_q ? ret_data : sc_hold_q;
        jd_rdata  = jd_hold_d;
        sc_rdata  = sc_hold_d;
        jd_rvalid = rv_jd_q;
        sc_rvalid = rv_sc_q;
    end

    // State, pointer and return-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pri_jd_q  <= 1'b1;
            rv_jd_q   <= 1'b0;
            rv_sc_q   <= 1'b0;
            hz_q      <= 1'b0;
            fwd_q     <= '0;
            jd_hold_q <= '0;
            sc_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pri_jd_q  <= pri_jd_d;
            rv_jd_q   <= jd_gnt;
            rv_sc_q   <= sc_gnt;
            hz_q      <= hz_d;
            fwd_q     <= ram_wr_data;
            jd_hold_q <= jd_hold_d;
            sc_hold_q <= sc_hold_d;
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a read-first, 1-cycle-latency RAM model.
module tb_board_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_start;
    logic       clear_busy, clear_done;
    logic       cm_req;
    logic [5:0] cm_addr;
    logic [1:0] cm_data;
    logic       cm_gnt;
    logic       jd_req;
    logic [5:0] jd_addr;
    logic       jd_gnt;
    logic [1:0] jd_rdata;
    logic       jd_rvalid;
    logic       sc_req;
    logic [5:0] sc_addr;
    logic       sc_gnt;
    logic [1:0] sc_rdata;
    logic       sc_rvalid;
    logic       ram_we;
    logic [5:0] ram_wr_addr;
    logic [1:0] ram_wr_data;
    logic [5:0] ram_rd_addr;
    logic [1:0] ram_rd_data;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] mem [64];
    logic [1:0] sc_exp [8];

    board_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .cm_req(cm_req), .cm_addr(cm_addr), .cm_data(cm_data), .cm_gnt(cm_gnt),
        .jd_req(jd_req), .jd_addr(jd_addr), .jd_gnt(jd_gnt),
        .jd_rdata(jd_rdata), .jd_rvalid(jd_rvalid),
        .sc_req(sc_req), .sc_addr(sc_addr), .sc_gnt(sc_gnt),
        .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .dbg_state(dbg_state)
    );

    // Clock and RAM model
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 2'b11;
        ram_rd_data = 2'b00;
    end

    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, failures=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cm_write(input logic [5:0] a, input logic [1:0] d);
        cm_req = 1'b1; cm_addr = a; cm_data = d;
        #1;
        check("cm_gnt_write", cm_gnt, 1);
        check("cm_we_write", ram_we, 1);
        tick();
        cm_req = 1'b0;
    endtask

    task automatic run_clear(input string tag);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            check({tag, "_we"}, ram_we, 1);
            check({tag, "_addr"}, ram_wr_addr, i);
            check({tag, "_data"}, ram_wr_data, 0);
            check({tag, "_busy"}, clear_busy, 1);
            check({tag, "_done_early"}, clear_done, 0);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_start = 1'b0;
        cm_req = 1'b0; cm_addr = '0; cm_data = '0;
        jd_req = 1'b0; jd_addr = '0;
        sc_req = 1'b0; sc_addr = '0;
        sc_exp[0] = 0; sc_exp[1] = 0; sc_exp[2] = 0; sc_exp[3] = 1;
        sc_exp[4] = 0; sc_exp[5] = 0; sc_exp[6] = 2; sc_exp[7] = 0;

        // Reset values
        #12;
        check("rst_busy", clear_busy, 0);
        check("rst_done", clear_done, 0);
        check("rst_jd_rvalid", jd_rvalid, 0);
        check("rst_sc_rvalid", sc_rvalid, 0);
        check("rst_jd_rdata", jd_rdata, 0);
        check("rst_sc_rdata", sc_rdata, 0);
        check("rst_we", ram_we, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Clear with a commit pending throughout
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cm_req = 1'b1; cm_addr = 6'd27; cm_data = 2'b01;
        for (int i = 0; i < 64; i++) begin
            #1;
            check("clr_we", ram_we, 1);
            check("clr_addr", ram_wr_addr, i);
            check("clr_data", ram_wr_data, 0);
            check("clr_busy", clear_busy, 1);
            check("clr_done_early", clear_done, 0);
            check("clr_cm_blocked", cm_gnt, 0);
            check("clr_state", dbg_state, 1);
            tick();
        end
        #1;
        check("done_pulse", clear_done, 1);
        check("done_busy", clear_busy, 0);
        check("done_cm_gnt", cm_gnt, 1);
        check("done_we", ram_we, 1);
        check("done_wr_addr", ram_wr_addr, 27);
        check("done_wr_data", ram_wr_data, 1);
        tick();
        cm_req = 1'b0;
        #1;
        check("after_done", clear_done, 0);
        check("after_we", ram_we, 0);
        check("after_state", dbg_state, 0);

        // Contention: J,S,J,S,J,S; judger reads 5 (00), scanner reads 27 (01)
        for (int k = 0; k < 6; k++) begin
            jd_req = 1'b1; jd_addr = 6'd5;
            sc_req = 1'b1; sc_addr = 6'd27;
            #1;
            check("arb_jd_gnt", jd_gnt, (k % 2 == 0));
            check("arb_sc_gnt", sc_gnt, (k % 2 == 1));
            check("arb_rd_addr", ram_rd_addr, (k % 2 == 0) ? 5 : 27);
            tick();
            check("arb_jd_rvalid", jd_rvalid, (k % 2 == 0));
            check("arb_sc_rvalid", sc_rvalid, (k % 2 == 1));
            check("arb_jd_rdata", jd_rdata, 0);
            if (k % 2 == 1) check("arb_sc_rdata", sc_rdata, 1);
        end
        jd_req = 1'b0; sc_req = 1'b0;

        // Same-cycle write/read hazard forwarding
        cm_req = 1'b1; cm_addr = 6'd12; cm_data = 2'b10;
        jd_req = 1'b1; jd_addr = 6'd12;
        #1;
        check("hz_cm_gnt", cm_gnt, 1);
        check("hz_jd_gnt", jd_gnt, 1);
        tick();
        cm_req = 1'b0; jd_req = 1'b0;
        check("hz_jd_rvalid", jd_rvalid, 1);
        check("hz_jd_rdata", jd_rdata, 2);
        check("hz_sc_rvalid", sc_rvalid, 0);
        check("hz_sc_hold", sc_rdata, 1);
        tick();
        check("hz_jd_hold", jd_rdata, 2);
        check("hz_jd_rvalid_off", jd_rvalid, 0);

        // Scanner-only burst over cells 0..7
        cm_write(6'd3, 2'b01);
        cm_write(6'd6, 2'b10);
        for (int i = 0; i < 8; i++) begin
            sc_req = 1'b1; sc_addr = 6'(i);
            #1;
            check("sc_gnt", sc_gnt, 1);
            check("sc_jd_gnt", jd_gnt, 0);
            check("sc_rd_addr", ram_rd_addr, i);
            tick();
            check("sc_rvalid", sc_rvalid, 1);
            check("sc_rdata", sc_rdata, sc_exp[i]);
            check("sc_jd_rvalid", jd_rvalid, 0);
        end
        sc_req = 1'b0;
        tick();
        check("sc_rvalid_off", sc_rvalid, 0);

        // Reset during clear at cycle 30
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 1; i < 30; i++) tick();
        #1;
        check("mid_busy", clear_busy, 1);
        check("mid_addr", ram_wr_addr, 29);
        rst_n = 1'b0;
        #1;
        check("abort_busy", clear_busy, 0);
        check("abort_done", clear_done, 0);
        check("abort_we", ram_we, 0);
        check("abort_jd_rdata", jd_rdata, 0);
        check("abort_sc_rdata", sc_rdata, 0);
        check("abort_state", dbg_state, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort_no_done", clear_done, 0);
        end

        // Fresh clear after the abort
        run_clear("clr2");
        #1;
        check("clr2_done", clear_done, 1);
        tick();
        check("clr2_done_off", clear_done, 0);

        // Cells written earlier now read back as cleared
        jd_req = 1'b1; jd_addr = 6'd6;
        tick();
        jd_req = 1'b0;
        check("post_rvalid", jd_rvalid, 1);
        check("post_rdata", jd_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
